lsb_commit: RTL and testbench
=============================

Name: lsb_commit

Overview:
- Parametrised load-store buffer for the out-of-order core.
- Sits between the decoder/dispatch, the reorder buffer (ROB), the common data buses (CDBs) and the memory controller.
- Accepts loads and stores in program order and captures operands from CDB_N result buses. Issues one memory access at a time from the queue head.
- Stores are decoupled from the ROB head: a store reports "ready" to the ROB and is written only after the ROB commits it. Committed stores survive a pipeline flush.

Parameters:
- LSB_BIT, 3: log2 of depth; depth LSB = 2**LSB_BIT.
- ROB_BIT, 3: ROB index width.
- CDB_N, 2: number of result broadcast buses snooped.
- IO_LO, 32'h30000: addresses >= IO_LO are I/O; loads there are non-speculative.
- FULL_SLACK, 2: lsb_full asserts when size + FULL_SLACK >= LSB.

Ports:
- clk_in  in  1  clock.
- rst_in  in  1  synchronous active-high reset.
- rdy_in  in  1  global enable; 0 freezes all state.
- rob_clear  in  1  flush of speculative state.
- rob_head_valid  in  1  ROB non-empty.
- rob_head_id  in  ROB_BIT  ROB head index.
- commit_valid  in  1  ROB commits an entry this cycle.
- commit_id  in  ROB_BIT  id of the committed entry.
- dc_valid  in  1  dispatch of one load/store.
- dc_op  in  10  {funct3, opcode}.
- dc_imm  in  32  address offset.
- dc_iQi, dc_iQj  in  1 each  operand ready (1 = no dependency).
- dc_Qi, dc_Qj  in  ROB_BIT each  producer tags.
- dc_Vi, dc_Vj  in  32 each  operand values (base, store data).
- dc_Qdest  in  ROB_BIT  ROB id of this instruction.
- lsb_full  out  1  dispatch back-pressure.
- cdb_valid  in  CDB_N  per-bus valid.
- cdb_id  in  CDB_N*ROB_BIT  packed tags.
- cdb_val  in  CDB_N*32  packed values.
- mem_req  out  1  request outstanding (level).
- mem_is_store  out  1  0 load, 1 store.
- mem_addr  out  32  access address.
- mem_data  out  32  store data.
- mem_op  out  3  funct3.
- mem_stuck  in  1  controller busy; no issue.
- mem_done  in  1  one-cycle completion pulse.
- mem_rdata  in  32  load data (already extended).
- lsb_out_valid  out  1  result/ready notification to the ROB.
- lsb_out_id  out  ROB_BIT  ROB id.
- lsb_out_val  out  32  load data; 0 for store-ready.

Behaviour:
- Circular queue with head, tail and size (LSB_BIT+1 bits); head and tail wrap modulo LSB.
- Per-entry state: op, imm, iQ1/Q1/V1, iQ2/Q2/V2, Qdest, reported, committed.
- Reset (rst_in=1 at a clock edge):
  - head = tail = size = 0.
  - mem_req = 0, ghost = 0.
  - All reported/committed bits = 0.
  - mem_is_store, mem_addr, mem_data, mem_op = 0.
  - lsb_out_valid = 0.
  - Reset wins over every other input, including mid-access; the memory controller is reset in the same cycle.
- Dispatch:
  - Written at tail.
  - An operand is captured as ready if dc_iQ is set or any valid CDB carries a matching tag that same cycle. The lowest-index bus wins on a duplicate tag.
- Wakeup: every entry with !iQ and a matching valid CDB tag sets iQ and latches V.
- Store-ready: a store with iQ1 && iQ2 && !reported is eligible for notification.
- Output port (registered, one cycle after the event):
  - Priority 1: a load mem_done that is not a ghost outputs {Qdest[head], mem_rdata}.
  - Priority 2: otherwise, the oldest eligible store outputs {Qdest, 0} and its reported bit is set.
- Commit: when commit_valid is set, the entry whose Qdest == commit_id and is a reported store sets committed.
- Issue: only when !mem_req && !mem_stuck && size != 0, at the head entry, with iQ1 && iQ2.
  - Store: requires committed.
  - Load, addr < IO_LO: issues immediately.
  - Load, addr >= IO_LO: requires rob_head_valid && rob_head_id == Qdest.
  - mem_addr = V1 + imm (mod 2^32). mem_data = V2.
- Completion: on mem_done, mem_req clears next cycle. Head advances and size decrements, unless ghost.
- Flush (rob_clear, not reset):
  - Keep the contiguous committed-store prefix starting at head; discard the rest.
  - tail = head + kept; size = kept; dispatch in the same cycle is ignored.
  - An in-flight load becomes a ghost: mem_req stays until mem_done, then clears with no pop and no output. Ghost clears then.
  - An in-flight store continues normally.
- Simultaneous events:
  - Dispatch + pop: size is unchanged.
  - A CDB match on the dispatch cycle is captured.
  - commit_valid for a store on the cycle it is popped cannot occur: a store issues only after it is committed.

Decomposition:
- Shared package/const header: LSB_BIT, ROB_BIT, opcode constants for load/store, funct3 encodings, IO_LO.
- One sub-module, lsb_cdb_snoop: combinational tag-match/select across CDB_N buses, returning hit and value. It is instantiated for each dispatch operand and each entry operand.

Test Plan:
- Dispatch load at addr 0x100 (Vi=0xF0, imm=0x10, ready); mem_done with 0xDEAD after 3 cycles -> mem_addr=0x100, then lsb_out {id, 0xDEAD}, and size returns to 0.
- Dispatch store (Qi pending tag 5), then CDB bus1 broadcasts {5, 0x2000} -> store-ready out with val 0. mem_req stays low until commit_id matches, then issues mem_addr=0x2000+imm.
- IO load at 0x30000 -> no issue while rob_head_id != Qdest; issues the cycle after they are equal.
- Two committed stores plus one uncommitted load queued, then rob_clear -> size=2. Both stores are written in order; no output for the load.
- Load in flight, then rob_clear, then mem_done -> no lsb_out_valid, head unchanged. The next dispatched load issues afterwards.
- Fill to LSB-FULL_SLACK entries -> lsb_full=1. With rdy_in=0 for 5 cycles mid-access -> all state frozen. A rst_in pulse mid-access -> all outputs at reset values.

Source files
------------

// File: rtl/lsb_commit_pkg.sv
// Shared constants and helpers for the load-store buffer.
package lsb_commit_pkg;

    localparam int          LSB_BIT_D    = 3;
    localparam int          ROB_BIT_D    = 3;
    localparam int          CDB_N_D      = 2;
    localparam int          FULL_SLACK_D = 2;
    localparam logic [31:0] IO_LO_D      = 32'h0003_0000;

    localparam logic [6:0]  OPC_LOAD     = 7'b000_0011;
    localparam logic [6:0]  OPC_STORE    = 7'b010_0011;

    typedef enum logic [2:0] {
        F3_B  = 3'd0,
        F3_H  = 3'd1,
        F3_W  = 3'd2,
        F3_BU = 3'd4,
        F3_HU = 3'd5
    } funct3_e;

    function automatic logic op_is_store(input logic [6:0] opcode);
        return opcode == OPC_STORE;
    endfunction

endpackage

// File: rtl/lsb_cdb_snoop.sv
// Tag match across all result buses; the lowest-index bus wins on duplicates.
module lsb_cdb_snoop #(
    parameter int ROB_BIT = 3,
    parameter int CDB_N   = 2
) (
    input  logic [ROB_BIT-1:0]       tag,
    input  logic [CDB_N-1:0]         cdb_valid,
    input  logic [CDB_N*ROB_BIT-1:0] cdb_id,
    input  logic [CDB_N*32-1:0]      cdb_val,
    output logic                     hit,
    output logic [31:0]              val
);

    always_comb begin
        hit = 1'b0;
        val = '0;
        for (int b = CDB_N - 1; b >= 0; b--) begin
            if (cdb_valid[b] && cdb_id[b*ROB_BIT +: ROB_BIT] == tag) begin
                hit = 1'b1;
                val = cdb_val[b*32 +: 32];
            end
        end
    end

endmodule

// File: rtl/lsb_commit.sv
// Load-store buffer: in-order issue from head, stores written only after ROB
// commit, committed stores survive a flush.
module lsb_commit
    import lsb_commit_pkg::*;
#(
    parameter int          LSB_BIT    = LSB_BIT_D,
    parameter int          ROB_BIT    = ROB_BIT_D,
    parameter int          CDB_N      = CDB_N_D,
    parameter logic [31:0] IO_LO      = IO_LO_D,
    parameter int          FULL_SLACK = FULL_SLACK_D
) (
    input  logic                     clk_in,
    input  logic                     rst_in,
    input  logic                     rdy_in,
    input  logic                     rob_clear,
    input  logic                     rob_head_valid,
    input  logic [ROB_BIT-1:0]       rob_head_id,
    input  logic                     commit_valid,
    input  logic [ROB_BIT-1:0]       commit_id,
    input  logic                     dc_valid,
    input  logic [9:0]               dc_op,
    input  logic [31:0]              dc_imm,
    input  logic                     dc_iQi,
    input  logic                     dc_iQj,
    input  logic [ROB_BIT-1:0]       dc_Qi,
    input  logic [ROB_BIT-1:0]       dc_Qj,
    input  logic [31:0]              dc_Vi,
    input  logic [31:0]              dc_Vj,
    input  logic [ROB_BIT-1:0]       dc_Qdest,
    output logic                     lsb_full,
    input  logic [CDB_N-1:0]         cdb_valid,
    input  logic [CDB_N*ROB_BIT-1:0] cdb_id,
    input  logic [CDB_N*32-1:0]      cdb_val,
    output logic                     mem_req,
    output logic                     mem_is_store,
    output logic [31:0]              mem_addr,
    output logic [31:0]              mem_data,
    output logic [2:0]               mem_op,
    input  logic                     mem_stuck,
    input  logic                     mem_done,
    input  logic [31:0]              mem_rdata,
    output logic                     lsb_out_valid,
    output logic [ROB_BIT-1:0]       lsb_out_id,
    output logic [31:0]              lsb_out_val
);

    localparam int LSB = 1 << LSB_BIT;

    // Entry storage
    logic [9:0]         op_reg    [LSB];
    logic [31:0]        imm_reg   [LSB];
    logic [ROB_BIT-1:0] q1_reg    [LSB];
    logic [ROB_BIT-1:0] q2_reg    [LSB];
    logic [ROB_BIT-1:0] qdest_reg [LSB];
    logic [31:0]        v1_reg    [LSB];
    logic [31:0]        v2_reg    [LSB];
    logic [LSB-1:0]     iq1_reg, iq2_reg, reported_reg, committed_reg;

    logic [LSB_BIT-1:0] head_reg, tail_reg, head_next, tail_next, head_after;
    logic [LSB_BIT:0]   size_reg, size_next, size_after, kept;

    logic               mem_req_reg, ghost_reg, mem_is_store_reg;
    logic [31:0]        mem_addr_reg, mem_data_reg;
    logic [2:0]         mem_op_reg;
    logic               out_valid_reg;
    logic [ROB_BIT-1:0] out_id_reg;
    logic [31:0]        out_val_reg;

    // Operand snooping: one matcher per entry operand plus the two dispatch operands
    logic [LSB-1:0] hit1, hit2;
    logic [31:0]    wval1 [LSB];
    logic [31:0]    wval2 [LSB];
    logic           dhit_i, dhit_j;
    logic [31:0]    dval_i, dval_j;

    for (genvar gi = 0; gi < LSB; gi++) begin : g_snoop
        lsb_cdb_snoop #(.ROB_BIT(ROB_BIT), .CDB_N(CDB_N)) u_snoop1 (
            .tag(q1_reg[gi]), .cdb_valid(cdb_valid), .cdb_id(cdb_id),
            .cdb_val(cdb_val), .hit(hit1[gi]), .val(wval1[gi])
        );
        lsb_cdb_snoop #(.ROB_BIT(ROB_BIT), .CDB_N(CDB_N)) u_snoop2 (
            .tag(q2_reg[gi]), .cdb_valid(cdb_valid), .cdb_id(cdb_id),
            .cdb_val(cdb_val), .hit(hit2[gi]), .val(wval2[gi])
        );
    end

    lsb_cdb_snoop #(.ROB_BIT(ROB_BIT), .CDB_N(CDB_N)) u_snoop_di (
        .tag(dc_Qi), .cdb_valid(cdb_valid), .cdb_id(cdb_id),
        .cdb_val(cdb_val), .hit(dhit_i), .val(dval_i)
    );
    lsb_cdb_snoop #(.ROB_BIT(ROB_BIT), .CDB_N(CDB_N)) u_snoop_dj (
        .tag(dc_Qj), .cdb_valid(cdb_valid), .cdb_id(cdb_id),
        .cdb_val(cdb_val), .hit(dhit_j), .val(dval_j)
    );

    // Head entry issue decision
    logic [31:0] head_addr;
    logic        head_store, can_issue, done, pop, push, load_out;

    assign head_addr  = v1_reg[head_reg] + imm_reg[head_reg];
    assign head_store = op_is_store(op_reg[head_reg][6:0]);
    assign done       = mem_req_reg && mem_done;
    assign pop        = done && !ghost_reg;
    assign load_out   = pop && !mem_is_store_reg && !rob_clear;
    assign push       = dc_valid && !rob_clear && size_reg != (LSB_BIT+1)'(LSB);

    always_comb begin
        can_issue = 1'b0;
        if (!mem_req_reg && !mem_stuck && size_reg != '0 && !rob_clear &&
            iq1_reg[head_reg] && iq2_reg[head_reg]) begin
            if (head_store)
                can_issue = committed_reg[head_reg];
            else
                can_issue = (head_addr < IO_LO) ||
                            (rob_head_valid && rob_head_id == qdest_reg[head_reg]);
        end
    end

    // Oldest store whose operands are complete and not yet announced to the ROB
    logic               rep_valid;
    logic [LSB_BIT-1:0] rep_idx, ridx;

    always_comb begin
        rep_valid = 1'b0;
        rep_idx   = '0;
        ridx      = '0;
        for (int k = 0; k < LSB; k++) begin
            ridx = head_reg + LSB_BIT'(k);
            if (!rep_valid && (LSB_BIT+1)'(k) < size_reg &&
                op_is_store(op_reg[ridx][6:0]) && iq1_reg[ridx] && iq2_reg[ridx] &&
                !reported_reg[ridx]) begin
                rep_valid = 1'b1;
                rep_idx   = ridx;
            end
        end
    end

    logic [LSB-1:0] commit_hit;

    always_comb begin
        commit_hit = '0;
        for (int i = 0; i < LSB; i++) begin
            commit_hit[i] = commit_valid && reported_reg[i] &&
                            op_is_store(op_reg[i][6:0]) && qdest_reg[i] == commit_id &&
                            ({1'b0, (LSB_BIT'(i) - head_reg)} < size_reg);
        end
    end

    // Flush keeps the committed-store run at the head (after any same-cycle pop)
    logic               run;
    logic [LSB_BIT-1:0] kidx;

    always_comb begin
        head_after = head_reg + LSB_BIT'(pop);
        size_after = size_reg - (LSB_BIT+1)'(pop);
        kept       = '0;
        run        = 1'b1;
        kidx       = '0;
        for (int k = 0; k < LSB; k++) begin
            kidx = head_after + LSB_BIT'(k);
            if (run && (LSB_BIT+1)'(k) < size_after &&
                op_is_store(op_reg[kidx][6:0]) && committed_reg[kidx])
                kept = kept + (LSB_BIT+1)'(1);
            else
                run = 1'b0;
        end
        head_next = head_after;
        if (rob_clear) begin
            tail_next = head_after + kept[LSB_BIT-1:0];
            size_next = kept;
        end else begin
            tail_next = tail_reg + LSB_BIT'(push);
            size_next = size_reg + (LSB_BIT+1)'(push) - (LSB_BIT+1)'(pop);
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            head_reg         <= '0;
            tail_reg         <= '0;
            size_reg         <= '0;
            mem_req_reg      <= 1'b0;
            ghost_reg        <= 1'b0;
            mem_is_store_reg <= 1'b0;
            mem_addr_reg     <= '0;
            mem_data_reg     <= '0;
            mem_op_reg       <= '0;
            out_valid_reg    <= 1'b0;
            out_id_reg       <= '0;
            out_val_reg      <= '0;
            iq1_reg          <= '0;
            iq2_reg          <= '0;
            reported_reg     <= '0;
            committed_reg    <= '0;
        end else if (rdy_in) begin
            head_reg <= head_next;
            tail_reg <= tail_next;
            size_reg <= size_next;

            if (done) begin
                mem_req_reg <= 1'b0;
                ghost_reg   <= 1'b0;
            end else if (can_issue) begin
                mem_req_reg      <= 1'b1;
                mem_is_store_reg <= head_store;
                mem_addr_reg     <= head_addr;
                mem_data_reg     <= v2_reg[head_reg];
                mem_op_reg       <= op_reg[head_reg][9:7];
            end else if (rob_clear && mem_req_reg && !mem_is_store_reg) begin
                ghost_reg <= 1'b1;
            end

            out_valid_reg <= 1'b0;
            if (load_out) begin
                out_valid_reg <= 1'b1;
                out_id_reg    <= qdest_reg[head_reg];
                out_val_reg   <= mem_rdata;
            end else if (rep_valid && !rob_clear) begin
                out_valid_reg <= 1'b1;
                out_id_reg    <= qdest_reg[rep_idx];
                out_val_reg   <= '0;
            end

            for (int i = 0; i < LSB; i++) begin
                if (push && tail_reg == LSB_BIT'(i)) begin
                    op_reg[i]        <= dc_op;
                    imm_reg[i]       <= dc_imm;
                    q1_reg[i]        <= dc_Qi;
                    q2_reg[i]        <= dc_Qj;
                    qdest_reg[i]     <= dc_Qdest;
                    iq1_reg[i]       <= dc_iQi || dhit_i;
                    iq2_reg[i]       <= dc_iQj || dhit_j;
                    v1_reg[i]        <= dc_iQi ? dc_Vi : dval_i;
                    v2_reg[i]        <= dc_iQj ? dc_Vj : dval_j;
                    reported_reg[i]  <= 1'b0;
                    committed_reg[i] <= 1'b0;
                end else begin
                    if (!iq1_reg[i] && hit1[i]) begin
                        iq1_reg[i] <= 1'b1;
                        v1_reg[i]  <= wval1[i];
                    end
                    if (!iq2_reg[i] && hit2[i]) begin
                        iq2_reg[i] <= 1'b1;
                        v2_reg[i]  <= wval2[i];
                    end
                    if (rep_valid && !load_out && !rob_clear && rep_idx == LSB_BIT'(i))
                        reported_reg[i] <= 1'b1;
                    if (commit_hit[i])
                        committed_reg[i] <= 1'b1;
                end
            end
        end
    end

    assign lsb_full      = (32'(size_reg) + 32'(FULL_SLACK)) >= 32'(LSB);
    assign mem_req       = mem_req_reg;
    assign mem_is_store  = mem_is_store_reg;
    assign mem_addr      = mem_addr_reg;
    assign mem_data      = mem_data_reg;
    assign mem_op        = mem_op_reg;
    assign lsb_out_valid = out_valid_reg;
    assign lsb_out_id    = out_id_reg;
    assign lsb_out_val   = out_val_reg;

endmodule

// File: tb/tb_lsb_commit.sv
// Directed bench for lsb_commit: load table plus store, I/O, flush, ghost and freeze sequences.
module tb_lsb_commit;
    import lsb_commit_pkg::*;

    logic        clk_in = 1'b0;
    logic        rst_in, rdy_in, rob_clear, rob_head_valid, commit_valid, dc_valid;
    logic [2:0]  rob_head_id, commit_id, dc_Qi, dc_Qj, dc_Qdest;
    logic [9:0]  dc_op;
    logic [31:0] dc_imm, dc_Vi, dc_Vj, mem_addr, mem_data, mem_rdata, lsb_out_val;
    logic        dc_iQi, dc_iQj, lsb_full, mem_req, mem_is_store, mem_stuck, mem_done;
    logic        lsb_out_valid;
    logic [1:0]  cdb_valid;
    logic [5:0]  cdb_id;
    logic [63:0] cdb_val;
    logic [2:0]  mem_op, lsb_out_id;

    int total = 0;
    int bad   = 0;

    always #5 clk_in = ~clk_in;

    lsb_commit dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .rob_clear(rob_clear),
        .rob_head_valid(rob_head_valid), .rob_head_id(rob_head_id),
        .commit_valid(commit_valid), .commit_id(commit_id),
        .dc_valid(dc_valid), .dc_op(dc_op), .dc_imm(dc_imm),
        .dc_iQi(dc_iQi), .dc_iQj(dc_iQj), .dc_Qi(dc_Qi), .dc_Qj(dc_Qj),
        .dc_Vi(dc_Vi), .dc_Vj(dc_Vj), .dc_Qdest(dc_Qdest), .lsb_full(lsb_full),
        .cdb_valid(cdb_valid), .cdb_id(cdb_id), .cdb_val(cdb_val),
        .mem_req(mem_req), .mem_is_store(mem_is_store), .mem_addr(mem_addr),
        .mem_data(mem_data), .mem_op(mem_op), .mem_stuck(mem_stuck),
        .mem_done(mem_done), .mem_rdata(mem_rdata),
        .lsb_out_valid(lsb_out_valid), .lsb_out_id(lsb_out_id), .lsb_out_val(lsb_out_val)
    );

    typedef struct {
        logic [31:0] vi;
        logic [31:0] imm;
        logic [2:0]  f3;
        logic [2:0]  qd;
        logic [31:0] rdata;
        logic [31:0] exp_addr;
    } ld_vec_t;

    ld_vec_t vecs [4];

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic chk1(input string nm, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b want %b", nm, act, exp);
        end
    endtask

    task automatic idle();
        rst_in = 0; rdy_in = 1; rob_clear = 0; rob_head_valid = 0; rob_head_id = 0;
        commit_valid = 0; commit_id = 0; dc_valid = 0; dc_op = 0; dc_imm = 0;
        dc_iQi = 0; dc_iQj = 0; dc_Qi = 0; dc_Qj = 0; dc_Vi = 0; dc_Vj = 0; dc_Qdest = 0;
        cdb_valid = 0; cdb_id = 0; cdb_val = 0; mem_stuck = 0; mem_done = 0; mem_rdata = 0;
    endtask

    task automatic dispatch(input logic [9:0] op, input logic [31:0] imm,
                            input logic iqi, input logic [2:0] qi, input logic [31:0] vi,
                            input logic iqj, input logic [2:0] qj, input logic [31:0] vj,
                            input logic [2:0] qd);
        dc_op = op; dc_imm = imm; dc_iQi = iqi; dc_Qi = qi; dc_Vi = vi;
        dc_iQj = iqj; dc_Qj = qj; dc_Vj = vj; dc_Qdest = qd; dc_valid = 1;
        tick();
        dc_valid = 0;
    endtask

    task automatic wait_req(input string nm);
        int n = 0;
        while (!mem_req && n < 20) begin
            tick();
            n++;
        end
        chk1(nm, mem_req, 1'b1);
    endtask

    task automatic wait_out(input string nm, input logic [2:0] id, input logic [31:0] val);
        int n = 0;
        while (!lsb_out_valid && n < 10) begin
            tick();
            n++;
        end
        chk1({nm, "_valid"}, lsb_out_valid, 1'b1);
        chk({nm, "_id"}, 32'(lsb_out_id), 32'(id));
        chk({nm, "_val"}, lsb_out_val, val);
    endtask

    task automatic complete(input logic [31:0] rdata);
        mem_rdata = rdata;
        mem_done  = 1;
        tick();
        mem_done  = 0;
    endtask

    initial begin
        int outs;

        vecs[0] = '{32'h0000_00F0, 32'h0000_0010, F3_W,  3'd1, 32'h0000_DEAD, 32'h0000_0100};
        vecs[1] = '{32'hFFFF_FFF0, 32'h0000_0020, F3_B,  3'd2, 32'hFFFF_FF80, 32'h0000_0010};
        vecs[2] = '{32'h0000_1000, 32'hFFFF_FFFC, F3_HU, 3'd3, 32'h0000_1234, 32'h0000_0FFC};
        vecs[3] = '{32'h0002_FFFC, 32'h0000_0003, F3_BU, 3'd4, 32'h0000_007F, 32'h0002_FFFF};

        idle();
        rst_in = 1;
        tick();
        tick();
        rst_in = 0;
        chk1("rst_mem_req", mem_req, 1'b0);
        chk1("rst_out_valid", lsb_out_valid, 1'b0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk1("rst_full", lsb_full, 1'b0);

        // Ordinary loads through the whole dispatch/issue/complete path
        for (int v = 0; v < 4; v++) begin
            dispatch({vecs[v].f3, OPC_LOAD}, vecs[v].imm, 1'b1, 3'd0, vecs[v].vi,
                     1'b1, 3'd0, 32'h0, vecs[v].qd);
            wait_req($sformatf("ld%0d_req", v));
            chk($sformatf("ld%0d_addr", v), mem_addr, vecs[v].exp_addr);
            chk($sformatf("ld%0d_op", v), 32'(mem_op), 32'(vecs[v].f3));
            chk1($sformatf("ld%0d_st", v), mem_is_store, 1'b0);
            tick(); tick(); tick();
            complete(vecs[v].rdata);
            chk1($sformatf("ld%0d_req_clr", v), mem_req, 1'b0);
            chk1($sformatf("ld%0d_ov", v), lsb_out_valid, 1'b1);
            chk($sformatf("ld%0d_oid", v), 32'(lsb_out_id), 32'(vecs[v].qd));
            chk($sformatf("ld%0d_oval", v), lsb_out_val, vecs[v].rdata);
            chk($sformatf("ld%0d_size", v), 32'(dut.size_reg), 32'd0);
            tick();
            chk1($sformatf("ld%0d_pulse", v), lsb_out_valid, 1'b0);
            $display("load vec %0d addr %h data %h", v, vecs[v].exp_addr, vecs[v].rdata);
        end

        // Duplicate tag on both buses during dispatch: bus 0 supplies the base
        cdb_valid = 2'b11; cdb_id = {3'd2, 3'd2}; cdb_val = {32'h900, 32'h100};
        dispatch({F3_W, OPC_LOAD}, 32'h8, 1'b0, 3'd2, 32'h0, 1'b1, 3'd0, 32'h0, 3'd7);
        cdb_valid = 0;
        wait_req("dup_req");
        chk("dup_addr", mem_addr, 32'h108);
        complete(32'h55);
        chk("dup_oid", 32'(lsb_out_id), 32'd7);
        $display("dup-tag load addr %h", mem_addr);

        // Store waits on a tag, reports ready, then issues only after commit
        dispatch({F3_W, OPC_STORE}, 32'h8, 1'b0, 3'd5, 32'h0, 1'b1, 3'd0, 32'hCAFE, 3'd6);
        chk1("st_early_out", lsb_out_valid, 1'b0);
        cdb_valid = 2'b11; cdb_id = {3'd5, 3'd3}; cdb_val = {32'h2000, 32'h999};
        tick();
        cdb_valid = 0;
        tick();
        chk1("st_ready_valid", lsb_out_valid, 1'b1);
        chk("st_ready_id", 32'(lsb_out_id), 32'd6);
        chk("st_ready_val", lsb_out_val, 32'h0);
        tick();
        chk1("st_ready_once", lsb_out_valid, 1'b0);
        commit_valid = 1; commit_id = 3'd7;
        tick();
        commit_valid = 0;
        tick(); tick();
        chk1("st_wrong_commit", mem_req, 1'b0);
        commit_valid = 1; commit_id = 3'd6;
        tick();
        commit_valid = 0;
        chk1("st_no_issue_yet", mem_req, 1'b0);
        tick();
        chk1("st_req", mem_req, 1'b1);
        chk1("st_is_store", mem_is_store, 1'b1);
        chk("st_addr", mem_addr, 32'h2008);
        chk("st_data", mem_data, 32'hCAFE);
        complete(32'h0);
        chk1("st_done_out", lsb_out_valid, 1'b0);
        chk("st_size", 32'(dut.size_reg), 32'd0);
        $display("store addr 2008 data cafe written");

        // I/O load waits for the ROB head
        rob_head_valid = 1; rob_head_id = 3'd0;
        dispatch({F3_W, OPC_LOAD}, 32'h0, 1'b1, 3'd0, 32'h0003_0000, 1'b1, 3'd0, 32'h0, 3'd3);
        tick(); tick(); tick(); tick();
        chk1("io_hold", mem_req, 1'b0);
        rob_head_valid = 0; rob_head_id = 3'd3;
        tick(); tick();
        chk1("io_hold_invalid", mem_req, 1'b0);
        rob_head_valid = 1;
        tick();
        chk1("io_req", mem_req, 1'b1);
        chk("io_addr", mem_addr, 32'h0003_0000);
        complete(32'hA5A5);
        chk("io_oval", lsb_out_val, 32'hA5A5);
        rob_head_valid = 0;
        $display("io load addr 30000 done");

        // Flush keeps two committed stores, drops the load behind them
        mem_stuck = 1;
        dispatch({F3_W, OPC_STORE}, 32'h0, 1'b1, 3'd0, 32'h40, 1'b1, 3'd0, 32'h11, 3'd1);
        wait_out("fl_a", 3'd1, 32'h0);
        dispatch({F3_W, OPC_STORE}, 32'h0, 1'b1, 3'd0, 32'h44, 1'b1, 3'd0, 32'h22, 3'd2);
        wait_out("fl_b", 3'd2, 32'h0);
        dispatch({F3_W, OPC_LOAD}, 32'h0, 1'b1, 3'd0, 32'h50, 1'b1, 3'd0, 32'h0, 3'd3);
        commit_valid = 1; commit_id = 3'd1;
        tick();
        commit_id = 3'd2;
        tick();
        commit_valid = 0;
        rob_clear = 1;
        dispatch({F3_W, OPC_LOAD}, 32'h0, 1'b1, 3'd0, 32'h60, 1'b1, 3'd0, 32'h0, 3'd4);
        rob_clear = 0;
        chk("fl_size", 32'(dut.size_reg), 32'd2);
        mem_stuck = 0;
        wait_req("fl_req_a");
        chk("fl_addr_a", mem_addr, 32'h40);
        chk("fl_data_a", mem_data, 32'h11);
        complete(32'h0);
        wait_req("fl_req_b");
        chk("fl_addr_b", mem_addr, 32'h44);
        chk("fl_data_b", mem_data, 32'h22);
        complete(32'h0);
        outs = 0;
        for (int c = 0; c < 4; c++) begin
            if (lsb_out_valid || mem_req) outs++;
            tick();
        end
        chk("fl_quiet", 32'(outs), 32'd0);
        chk("fl_size_end", 32'(dut.size_reg), 32'd0);
        $display("flush kept stores 40,44");

        // In-flight load becomes a ghost across a flush
        dispatch({F3_W, OPC_LOAD}, 32'h0, 1'b1, 3'd0, 32'h200, 1'b1, 3'd0, 32'h0, 3'd4);
        wait_req("gh_req");
        rob_clear = 1;
        tick();
        rob_clear = 0;
        chk1("gh_req_hold", mem_req, 1'b1);
        chk("gh_size", 32'(dut.size_reg), 32'd0);
        tick(); tick();
        complete(32'hBAD);
        chk1("gh_req_clr", mem_req, 1'b0);
        chk1("gh_no_out", lsb_out_valid, 1'b0);
        dispatch({F3_W, OPC_LOAD}, 32'h0, 1'b1, 3'd0, 32'h300, 1'b1, 3'd0, 32'h0, 3'd5);
        wait_req("gh_next_req");
        chk("gh_next_addr", mem_addr, 32'h300);
        complete(32'h77);
        chk("gh_next_oid", 32'(lsb_out_id), 32'd5);
        chk("gh_next_oval", lsb_out_val, 32'h77);
        $display("ghost load dropped, next load addr 300");

        // Fill to the slack threshold, freeze, then reset mid-access
        mem_stuck = 1;
        for (int i = 0; i < 6; i++) begin
            dispatch({F3_W, OPC_LOAD}, 32'h0, 1'b1, 3'd0, 32'h400 + 32'(i) * 4,
                     1'b1, 3'd0, 32'h0, 3'(i));
            chk1($sformatf("full_%0d", i + 1), lsb_full, (i + 1) >= 6);
        end
        mem_stuck = 0;
        wait_req("frz_req");
        chk("frz_addr0", mem_addr, 32'h400);
        rdy_in = 0;
        dc_valid = 1;
        for (int c = 0; c < 5; c++) begin
            mem_done = (c == 2);
            tick();
        end
        mem_done = 0;
        dc_valid = 0;
        chk1("frz_req", mem_req, 1'b1);
        chk("frz_addr", mem_addr, 32'h400);
        chk1("frz_full", lsb_full, 1'b1);
        chk("frz_size", 32'(dut.size_reg), 32'd6);
        chk1("frz_out", lsb_out_valid, 1'b0);
        rdy_in = 1;
        rst_in = 1;
        tick();
        rst_in = 0;
        chk1("rst2_req", mem_req, 1'b0);
        chk1("rst2_st", mem_is_store, 1'b0);
        chk("rst2_addr", mem_addr, 32'h0);
        chk("rst2_data", mem_data, 32'h0);
        chk("rst2_op", 32'(mem_op), 32'h0);
        chk1("rst2_out", lsb_out_valid, 1'b0);
        chk1("rst2_full", lsb_full, 1'b0);
        $display("freeze and mid-access reset done");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
